// File: rtl/qspi_fifo_sched.sv
// qspi_fifo_sched: write arbiter, occupancy tracker and read-burst sequencer for the
// 256-entry QSPI data FIFO.
//
// Write side: requesters A (CPU register path) and B (DMA) are round-robin arbitrated onto
// the FIFO write port. Ready is combinational and equals the grant, so an accepted word
// reaches fifo_wdata_o with fifo_wr_en_o in the same cycle.
//
// Read side: a start_i pulse with a non-zero burst_len_i sends that many FIFO words to the
// shift engine over a valid/ready stream, one word per RD -> WAIT -> SEND round trip.
//
// Occupancy is counted here from the issued strobes; the FIFO's own flags are not used.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   a_valid_i/a_data_i/a_ready_o requester A word offer / accept
//   b_valid_i/b_data_i/b_ready_o requester B word offer / accept
//   fifo_wr_en_o, fifo_wdata_o   FIFO write port
//   fifo_rd_en_o, fifo_rdata_i   FIFO read strobe, registered read data (next cycle)
//   start_i, burst_len_i         burst request and word count
//   busy_o, done_o               burst in progress, one-cycle completion pulse
//   tx_valid_o/tx_data_o/tx_ready_i  stream to the shift engine
//   level_o                      current FIFO occupancy
module qspi_fifo_sched #(
  parameter int unsigned DW        = 32,
  parameter int unsigned DEPTH_MAX = 255,
  parameter int unsigned LW        = 9
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // Requester A
  input  logic          a_valid_i,
  input  logic [DW-1:0] a_data_i,
  output logic          a_ready_o,
  // Requester B
  input  logic          b_valid_i,
  input  logic [DW-1:0] b_data_i,
  output logic          b_ready_o,
  // FIFO ports
  output logic          fifo_wr_en_o,
  output logic [DW-1:0] fifo_wdata_o,
  output logic          fifo_rd_en_o,
  input  logic [DW-1:0] fifo_rdata_i,
  // Burst control
  input  logic          start_i,
  input  logic [LW-1:0] burst_len_i,
  output logic          busy_o,
  output logic          done_o,
  // Shift-engine stream
  output logic          tx_valid_o,
  output logic [DW-1:0] tx_data_o,
  input  logic          tx_ready_i,
  // Occupancy
  output logic [LW-1:0] level_o
);

  localparam logic [LW-1:0] LevelMax = LW'(DEPTH_MAX);
  localparam logic [LW-1:0] LevelOne = LW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWait,
    StSend,
    StDone
  } state_e;

  // Occupancy and arbitration state
  logic [LW-1:0] level_q, level_d;
  logic          prio_q, prio_d;  // 0: A holds priority, 1: B holds priority

  // Burst FSM state and registered outputs
  state_e        state_q;
  logic [LW-1:0] rem_q;
  logic          busy_q;
  logic          done_q;
  logic          tx_valid_q;
  logic [DW-1:0] tx_data_q;

  logic can_wr;
  logic grant_a;
  logic grant_b;
  logic rd_en;

  // ---------------------------------------------------------------------------
  // Write arbitration
  // ---------------------------------------------------------------------------
  // Space is judged on the current level only: a read issued in the same cycle does not
  // free a slot for a write until the next cycle.
  always_comb begin
    can_wr  = (level_q < LevelMax);
    grant_a = can_wr & a_valid_i & (~b_valid_i | ~prio_q);
    grant_b = can_wr & b_valid_i & (~a_valid_i |  prio_q);
  end

  assign a_ready_o    = grant_a;
  assign b_ready_o    = grant_b;
  assign fifo_wr_en_o = grant_a | grant_b;
  assign fifo_wdata_o = grant_b ? b_data_i : a_data_i;

  // The read strobe must fire in the RD cycle itself so the registered FIFO data lands in
  // WAIT; it is therefore decoded from the state rather than registered.
  assign rd_en        = (state_q == StRd) && (level_q != '0);
  assign fifo_rd_en_o = rd_en;

  // ---------------------------------------------------------------------------
  // Occupancy counter and priority pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    level_d = level_q;
    case ({fifo_wr_en_o, rd_en})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;  // idle, or write and read cancel out
    endcase

    prio_d = prio_q;
    if (grant_a) begin
      prio_d = 1'b1;
    end else if (grant_b) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      prio_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      prio_q  <= prio_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-burst FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // Zero-length requests are dropped without any visible effect.
          if (start_i && (burst_len_i != '0)) begin
            rem_q   <= burst_len_i;
            busy_q  <= 1'b1;
            state_q <= StRd;
          end
        end
        StRd: begin
          // Stall here until a requester has put a word into the FIFO.
          if (level_q != '0) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          tx_data_q  <= fifo_rdata_i;
          tx_valid_q <= 1'b1;
          state_q    <= StSend;
        end
        StSend: begin
          if (tx_ready_i) begin
            tx_valid_q <= 1'b0;
            rem_q      <= rem_q - LevelOne;
            if (rem_q == LevelOne) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o  = tx_data_q;
  assign level_o    = level_q;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_no_wr_full: assert property (@(posedge clk_i) disable iff (rst_i)
      !(fifo_wr_en_o && (level_q == LevelMax)));

  a_no_rd_empty: assert property (@(posedge clk_i) disable iff (rst_i)
      !(fifo_rd_en_o && (level_q == '0)));

  a_tx_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (tx_valid_o && !tx_ready_i) |=> (tx_valid_o && $stable(tx_data_o)));

endmodule

// File: tb/tb_qspi_fifo_sched.sv
// Self-checking bench for qspi_fifo_sched. A simple FIFO memory stands in for the real
// FIFO; a negedge monitor compares every DUT output against a reference model made of a
// word queue (everything accepted but not yet transmitted), a level count, the round-robin
// priority bit and a burst word counter.
module tb_qspi_fifo_sched;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [DW-1:0] a_data, b_data;
  logic          fifo_wr_en, fifo_rd_en;
  logic [DW-1:0] fifo_wdata, fifo_rdata;
  logic          start, busy, done;
  logic [LW-1:0] burst_len, level;
  logic          tx_valid, tx_ready;
  logic [DW-1:0] tx_data;

  always #5 clk = ~clk;

  qspi_fifo_sched #(.DW(DW), .DEPTH_MAX(255), .LW(LW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .a_valid_i    (a_valid),
    .a_data_i     (a_data),
    .a_ready_o    (a_ready),
    .b_valid_i    (b_valid),
    .b_data_i     (b_data),
    .b_ready_o    (b_ready),
    .fifo_wr_en_o (fifo_wr_en),
    .fifo_wdata_o (fifo_wdata),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_rdata_i (fifo_rdata),
    .start_i      (start),
    .burst_len_i  (burst_len),
    .busy_o       (busy),
    .done_o       (done),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .tx_ready_i   (tx_ready),
    .level_o      (level)
  );

  // Stand-in FIFO: registered read data, reset with the controller.
  logic [DW-1:0] fmem [256];
  logic [7:0]    fw, fr;
  always @(posedge clk) begin
    if (rst) begin
      fw <= 8'd0;
      fr <= 8'd0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_wr_en) begin
        fmem[fw] <= fifo_wdata;
        fw <= fw + 8'd1;
      end
      if (fifo_rd_en) begin
        fifo_rdata <= fmem[fr];
        fr <= fr + 8'd1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state
  logic          m_prio, m_busy, m_done, nb, nd, ea, eb, full, hs, prev_hold;
  int            m_level, m_rem;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] prev_data, exp_w;
  int            hs_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
  int            hs_cyc[$];

  always @(negedge clk) begin
    if (rst) begin
      m_prio = 1'b0; m_level = 0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
      sb.delete();
      prev_hold = 1'b0;
    end else begin
      full = (m_level >= 255);
      ea = a_valid && !full && (!b_valid || !m_prio);
      eb = b_valid && !full && (!a_valid || m_prio);
      hs = tx_valid && tx_ready;
      chk("a_ready", 32'(a_ready), 32'(ea));
      chk("b_ready", 32'(b_ready), 32'(eb));
      chk("fifo_wr_en", 32'(fifo_wr_en), 32'(ea || eb));
      if (ea) chk("fifo_wdata_a", fifo_wdata, a_data);
      if (eb) chk("fifo_wdata_b", fifo_wdata, b_data);
      chk("level", 32'(level), 32'(m_level));
      if (fifo_rd_en) chk("rd_legal", 32'(m_level != 0 && m_busy), 1);
      if (prev_hold) begin
        chk("tx_valid_hold", 32'(tx_valid), 1);
        chk("tx_data_hold", tx_data, prev_data);
      end
      if (!m_busy) chk("tx_idle", 32'(tx_valid), 0);
      if (hs) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_extra: got word 0x%0h, required no word (cycle %0d)", tx_data, cyc);
        end else begin
          exp_w = sb.pop_front();
          chk("tx_data", tx_data, exp_w);
        end
        hs_cnt++;
        hs_cyc.push_back(cyc);
      end
      chk("done", 32'(done), 32'(m_done));
      chk("busy", 32'(busy), 32'(m_busy));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      // Advance the model to the next cycle.
      if (ea) begin
        sb.push_back(a_data);
        m_prio = 1'b1;
      end else if (eb) begin
        sb.push_back(b_data);
        m_prio = 1'b0;
      end
      m_level = m_level + ((ea || eb) ? 1 : 0) - (fifo_rd_en ? 1 : 0);
      nb = m_busy;
      nd = 1'b0;
      if (!m_busy && !m_done && start && burst_len != '0) begin
        nb = 1'b1;
        m_rem = int'(burst_len);
        start_cyc = cyc;
      end
      if (hs && m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          nb = 1'b0;
          nd = 1'b1;
        end
      end
      m_busy = nb;
      m_done = nd;
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
    end
  end

  logic a_acc, b_acc;

  // One clock: observe acceptance at the negedge, return just after the next posedge.
  task automatic tick();
    @(negedge clk);
    a_acc = a_valid && a_ready;
    b_acc = b_valid && b_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; start = 1'b0; tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int k = 0;
    while (done_cnt == base && k < budget) begin
      tick();
      k++;
    end
    chk(name, 32'(done_cnt != base), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int acc, base, k;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    start = 1'b0; burst_len = '0; tx_ready = 1'b0;
    a_acc = 1'b0; b_acc = 1'b0;

    // Reset values
    do_reset();
    chk("rst_a_ready", 32'(a_ready), 0);
    chk("rst_b_ready", 32'(b_ready), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", 32'(level), 0);

    // Three consecutive A writes
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1;
      a_data = 32'hA0 + 32'(i);
      tick();
      chk("t2_accept", 32'(a_acc), 1);
    end
    a_valid = 1'b0;
    chk("t2_level", 32'(level), 3);

    // Both requesters busy: strict alternation starting with A
    do_reset();
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 32'hAAAA_0000; b_data = 32'hBBBB_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_grant_a", 32'(a_acc), 32'(i % 2 == 0));
      chk("t3_grant_b", 32'(b_acc), 32'(i % 2 == 1));
      if (a_acc) a_data = a_data + 32'd1;
      if (b_acc) b_data = b_data + 32'd1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_level", 32'(level), 4);

    // Fill to capacity, then a read at full must still refuse the write
    do_reset();
    acc = 0;
    a_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a_data = 32'h1000 + 32'(acc);
      tick();
      if (a_acc) acc++;
    end
    chk("t4_accepted", 32'(acc), 255);
    chk("t4_level", 32'(level), 255);
    chk("t4_ready_full", 32'(a_ready), 0);
    base = done_cnt;
    start = 1'b1; burst_len = 9'd1; tx_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_rd_at_full", 32'(fifo_rd_en), 1);
    chk("t4_no_wr_at_full", 32'(a_ready), 0);
    tick();
    chk("t4_level_after_rd", 32'(level), 254);
    chk("t4_ready_after_rd", 32'(a_ready), 1);
    tick();
    a_valid = 1'b0;
    wait_done(base, 20, "t4_done_timeout");

    // Preloaded 5-word burst at full throughput
    do_reset();
    b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_data = $urandom;
      tick();
    end
    b_valid = 1'b0;
    tx_ready = 1'b1;
    hs_cyc.delete();
    base = done_cnt;
    acc = hs_cnt;
    start = 1'b1; burst_len = 9'd5;
    tick();
    start = 1'b0;
    wait_done(base, 60, "t5_done_timeout");
    repeat (4) tick();
    chk("t5_words", 32'(hs_cnt - acc), 5);
    if (hs_cyc.size() == 5) begin
      chk("t5_first_latency", 32'(hs_cyc[0] - start_cyc), 3);
      for (int i = 1; i < 5; i++) chk("t5_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 3);
    end
    chk("t5_done_time", 32'(done_cyc - start_cyc), 16);
    chk("t5_done_once", 32'(done_cnt - base), 1);
    chk("t5_level", 32'(level), 0);
    chk("t5_busy", 32'(busy), 0);

    // Zero-length start is ignored; then a burst that stalls on an empty FIFO
    do_reset();
    base = done_cnt;
    start = 1'b1; burst_len = '0;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("t6_zero_busy", 32'(busy), 0);
    chk("t6_zero_done", 32'(done_cnt - base), 0);
    tx_ready = 1'b1;
    acc = hs_cnt;
    start = 1'b1; burst_len = 9'd4;
    tick();
    start = 1'b0;
    for (int w = 0; w < 4; w++) begin
      repeat (9) tick();
      b_valid = 1'b1;
      b_data = $urandom;
      tick();
      chk("t6_b_accept", 32'(b_acc), 1);
      b_valid = 1'b0;
    end
    wait_done(base, 40, "t6_done_timeout");
    chk("t6_words", 32'(hs_cnt - acc), 4);
    chk("t6_done_once", 32'(done_cnt - base), 1);

    // Back-pressure hold, then reset in SEND
    do_reset();
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_data = $urandom;
      tick();
    end
    a_valid = 1'b0;
    start = 1'b1; burst_len = 9'd4;
    tick();
    start = 1'b0;
    k = 0;
    while (!tx_valid && k < 10) begin tick(); k++; end
    chk("t7_tx_valid_seen", 32'(tx_valid), 1);
    repeat (6) tick();
    chk("t7_held_valid", 32'(tx_valid), 1);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    k = 0;
    while (!tx_valid && k < 10) begin tick(); k++; end
    chk("t7_tx_valid_again", 32'(tx_valid), 1);
    base = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_tx_valid", 32'(tx_valid), 0);
    chk("t7_rst_level", 32'(level), 0);
    chk("t7_rst_busy", 32'(busy), 0);
    a_valid = 1'b1; b_valid = 1'b1;
    tick();
    chk("t7_prio_a", 32'(a_acc), 1);
    chk("t7_prio_b", 32'(b_acc), 0);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) tick();
    chk("t7_no_done", 32'(done_cnt - base), 0);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (!a_valid || a_acc) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_data = $urandom;
      end
      if (!b_valid || b_acc) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_data = $urandom;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 15) == 0);
      burst_len = 9'($urandom_range(0, 12));
      tick();
    end
    start = 1'b0;
    tx_ready = 1'b1;
    k = 0;
    while ((busy || done) && k < 2000) begin
      if (!a_valid || a_acc) begin
        a_valid = ($urandom_range(0, 1) != 0);
        a_data = $urandom;
      end
      tick();
      k++;
    end
    chk("t8_drained", 32'(busy), 0);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
